uart_hex_tx_formatter: RTL and testbench

Upstream feeder for the UART transmitter. Buffers fixed-width data words in a small FIFO and converts each word to uppercase ASCII hex characters, optionally followed by CR LF. Characters go to the transmitter one at a time over its data/data_valid/tx_ack four-phase handshake. Sits between measurement/status logic and the UART TX byte interface.

---
 rtl/uart_hex_tx_formatter_if.sv | 23 ++
 rtl/uart_hex_tx_formatter.sv | 106 ++++++++++
 tb/tb_uart_hex_tx_formatter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_tx_formatter_if.sv
// Word-in / ASCII-byte-out bundle for the hex formatter: upstream push port,
// downstream four-phase byte handshake and the busy flag.
interface uart_hex_tx_formatter_if #(
  parameter int unsigned WORD_W = 16
);
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        data;
  logic              data_valid;
  logic              tx_ack;
  logic              busy;

  modport master (
    output in_word, in_valid, tx_ack,
    input  in_ready, data, data_valid, busy
  );

  modport slave (
    input  in_word, in_valid, tx_ack,
    output in_ready, data, data_valid, busy
  );
endinterface

// File: rtl/uart_hex_tx_formatter.sv
// Buffers words in a small FIFO and emits each as uppercase ASCII hex digits
// (MS nibble first), optionally followed by CR LF, over a four-phase handshake.
module uart_hex_tx_formatter #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TERM_CRLF  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  uart_hex_tx_formatter_if.slave bus
);
  localparam int unsigned NDIG   = WORD_W / 4;
  localparam int unsigned NCHARS = NDIG + 2 * TERM_CRLF;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned IW     = $clog2(NCHARS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, RELEASE} state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;
  logic [WORD_W-1:0] shreg;
  logic [IW-1:0]     idx;
  logic              last_char;
  logic [3:0]        nib;
  logic [7:0]        cur_char;

  // in_ready comes from the registered count only, so a pop at full never
  // opens a same-cycle push slot.
  assign push      = bus.in_valid && bus.in_ready;
  assign pop       = (state == LOAD);
  assign last_char = (idx == IW'(NCHARS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= bus.in_word;
  end

  // Current nibble always sits in the top of shreg; it shifts on each advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (state == LOAD) begin
      shreg <= mem[rd_ptr];
      idx   <= '0;
    end else if (state == RELEASE && !bus.tx_ack && !last_char) begin
      shreg <= shreg << 4;
      idx   <= idx + 1'b1;
    end
  end

  always_comb begin
    nib = shreg[WORD_W-1 -: 4];
    if (idx < IW'(NDIG)) begin
      cur_char = (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
    end else if (idx == IW'(NDIG)) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (bus.tx_ack) state_next = RELEASE;
      RELEASE: begin
        if (!bus.tx_ack) begin
          if (!last_char)        state_next = SEND;
          else if (count != '0) state_next = LOAD;
          else                   state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (count != CW'(FIFO_DEPTH));
    bus.data_valid = (state == SEND);
    bus.data       = (state == SEND) ? cur_char : 8'h00;
    bus.busy       = (count != '0) || (state != IDLE);
  end
endmodule

// File: tb/tb_uart_hex_tx_formatter.sv
// Randomised bench for uart_hex_tx_formatter: scoreboard of expected ASCII
// bytes built from the word values, compared against the captured byte stream.
module tb_uart_hex_tx_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_hex_tx_formatter_if #(.WORD_W(16)) bus ();
  uart_hex_tx_formatter_if #(.WORD_W(8))  bus8 ();

  uart_hex_tx_formatter #(.WORD_W(16), .FIFO_DEPTH(8), .TERM_CRLF(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  uart_hex_tx_formatter #(.WORD_W(8), .FIFO_DEPTH(8), .TERM_CRLF(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  int unsigned total = 0, passed = 0, fails = 0;
  int unsigned cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  bit          resp_en = 1'b0;
  logic        man_ack = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned wait_cnt = 0;
  logic [7:0]  cap_q[$];
  int unsigned rise_cyc[$];
  logic [7:0]  exp_q[$];
  bit          prev_dv = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int unsigned stab_err = 0;
  int unsigned last_acc = 0;

  // Byte monitor and transmitter model, both acting on the falling edge.
  initial begin
    bus.tx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.data_valid && !prev_dv) begin
        cap_q.push_back(bus.data);
        rise_cyc.push_back(cyc);
      end
      if (bus.data_valid && prev_dv && bus.data !== prev_data) stab_err++;
      prev_dv   = bus.data_valid;
      prev_data = bus.data;
      if (resp_en) begin
        if (bus.data_valid && !bus.tx_ack) begin
          if (wait_cnt >= ack_delay) bus.tx_ack = 1'b1;
          else wait_cnt++;
        end else if (!bus.data_valid) begin
          bus.tx_ack = 1'b0;
          wait_cnt   = 0;
        end
      end else begin
        bus.tx_ack = man_ack;
        wait_cnt   = 0;
      end
    end
  end

  function automatic logic [7:0] hex_char(input logic [31:0] w, input int unsigned width,
                                          input int unsigned k);
    int unsigned digits = width / 4;
    int unsigned n;
    if (k < digits) begin
      n = (w >> (4 * (digits - 1 - k))) % 16;
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    end
    return (k == digits) ? 8'h0D : 8'h0A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [15:0] w);
    for (int unsigned k = 0; k < 6; k++) exp_q.push_back(hex_char(32'(w), 16, k));
  endtask

  // Call at a falling edge; returns at a falling edge with in_valid low.
  task automatic push_word(input logic [15:0] w, input bit model);
    int unsigned n = 0;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk);
    if (model) model_word(w);
    #1 last_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned nbytes);
    int unsigned n = 0;
    while ((cap_q.size() < nbytes || bus.busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_dv(input logic level);
    int unsigned n = 0;
    while (bus.data_valid !== level && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_dv", 32'(bus.data_valid), 32'(level));
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, cap_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size(); i++)
      check(tag, (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    check({tag, "_stable"}, stab_err, 0);
    cap_q.delete();
    exp_q.delete();
    rise_cyc.delete();
    stab_err = 0;
  endtask

  initial begin
    logic [15:0] words [10];
    int unsigned accepted, acc, snap;
    bit ready_now;
    logic [7:0] cap8[$];

    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus8.in_valid = 1'b0;
    bus8.in_word  = '0;
    bus8.tx_ack   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, slow acknowledger; also measures first-byte latency.
    resp_en   = 1'b1;
    ack_delay = 20;
    push_word(16'h1A2F, 1'b1);
    acc = last_acc;
    wait_drain(6);
    check("latency", (rise_cyc.size() > 0) ? rise_cyc[0] - acc : 32'hffff_ffff, 32'd2);
    check("idle_dv", 32'(bus.data_valid), 32'd0);
    cmp_stream("word_1a2f");

    // Back-to-back extremes.
    ack_delay = $urandom_range(0, 3);
    push_word(16'h0000, 1'b1);
    push_word(16'hFFFF, 1'b1);
    wait_drain(12);
    cmp_stream("b2b_0000_ffff");

    // Random words, random gaps and acknowledge delays.
    for (int unsigned i = 0; i < 10; i++) begin
      ack_delay = $urandom_range(0, 5);
      push_word(16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain(60);
    cmp_stream("random");

    // Transmitter stalled: FIFO fills, ninth word is the last accepted.
    resp_en  = 1'b0;
    man_ack  = 1'b0;
    accepted = 0;
    for (int unsigned i = 0; i < 10; i++) words[i] = 16'($urandom);
    for (int unsigned c = 0; c < 60; c++) begin
      if (accepted < 10) begin
        bus.in_valid = 1'b1;
        bus.in_word  = words[accepted];
      end else begin
        bus.in_valid = 1'b0;
      end
      ready_now = bus.in_ready;
      @(negedge clk);
      if (ready_now && accepted < 10) begin
        model_word(words[accepted]);
        accepted++;
      end
    end
    bus.in_valid = 1'b0;
    check("stall_accepted", accepted, 9);
    check("stall_ready", 32'(bus.in_ready), 32'd0);
    check("stall_dv", 32'(bus.data_valid), 32'd1);
    check("stall_busy", 32'(bus.busy), 32'd1);
    ack_delay = $urandom_range(0, 4);
    resp_en   = 1'b1;
    wait_drain(54);
    cmp_stream("stall_drain");

    // 8-bit words, no terminator.
    bus8.in_valid = 1'b1;
    bus8.in_word  = 8'hC3;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    for (int unsigned c = 0; c < 60; c++) begin
      if (bus8.data_valid && !bus8.tx_ack) begin
        cap8.push_back(bus8.data);
        bus8.tx_ack = 1'b1;
      end else if (!bus8.data_valid) begin
        bus8.tx_ack = 1'b0;
      end
      @(negedge clk);
    end
    check("w8_len", cap8.size(), 2);
    for (int unsigned k = 0; k < 2; k++)
      check("w8_byte", (k < cap8.size()) ? 32'(cap8[k]) : 32'hxxxx_xxxx,
            32'(hex_char(32'h00C3, 8, k)));
    check("w8_busy", 32'(bus8.busy), 32'd0);

    // Reset while the second character of a word is on offer.
    resp_en = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) push_word(16'($urandom), 1'b0);
    wait_dv(1'b1);
    man_ack = 1'b1;
    wait_dv(1'b0);
    man_ack = 1'b0;
    wait_dv(1'b1);
    check("rst_mid_queued", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_dv", 32'(bus.data_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    rst_n   = 1'b1;
    snap    = cap_q.size();
    man_ack = 1'b1;
    repeat (3) @(negedge clk);
    man_ack = 1'b0;
    repeat (20) @(negedge clk);
    check("stale_ack_bytes", cap_q.size(), snap);
    check("stale_ack_dv", 32'(bus.data_valid), 32'd0);
    check("stale_ack_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
